id_ex_stage: RTL and testbench
==============================

// Module: id_ex_stage
// PURPOSE
//  ID/EX pipeline register directly upstream of ALUdec/ALU. Captures decoded fields, selects and
//  forwards ALU operands A/B and store data, then drives opcode/funct/add_rshift_type and A/B to
//  the execute stage. Provides a valid/ready handshake, load-use stall detection and flush.
// PARAMETERS
//  XLEN        32  datapath width
//  REG_ADDR_W  5   register index width
// PORTS
//  Clock            in   1      rising-edge clock
//  Reset_n          in   1      asynchronous, active-low reset
//  flush            in   1      kill the held instruction and the incoming instruction (branch/jump redirect)
//  in_valid         in   1      decoded instruction present
//  in_ready         out  1      stage accepts the instruction this cycle
//  in_opcode        in   7      opcode, encodings from Opcode.vh
//  in_funct         in   3      funct3
//  in_add_rshift    in   1      instr[30]
//  in_pc            in   XLEN   instruction PC
//  in_imm           in   XLEN   sign-extended immediate; zimm for CSR-immediate forms
//  in_rs1, in_rs2   in   5      source register indices
//  in_rs1_data      in   XLEN   register-file read data for rs1
//  in_rs2_data      in   XLEN   register-file read data for rs2
//  in_rd            in   5      destination register index
//  ex_fwd_valid     in   1      EX/MEM stage writes a register
//  ex_fwd_is_load   in   1      EX/MEM result is a pending load; data not yet available
//  ex_fwd_rd        in   5      EX/MEM destination register
//  ex_fwd_data      in   XLEN   EX/MEM ALU result
//  wb_fwd_valid     in   1      MEM/WB stage writes a register
//  wb_fwd_rd        in   5      MEM/WB destination register
//  wb_fwd_data      in   XLEN   MEM/WB writeback data
//  out_valid        out  1      execute-stage payload valid
//  out_ready        in   1      execute stage consumes the payload
//  out_opcode       out  7      to ALUdec
//  out_funct        out  3      to ALUdec
//  out_add_rshift   out  1      to ALUdec
//  out_A, out_B     out  XLEN   ALU operands
//  out_store_data   out  XLEN   forwarded rs2 value, used for STORE
//  out_rd           out  5      destination register
//  out_pc           out  XLEN   PC, kept for link value and branch target
// BEHAVIOUR
//  Reset: out_valid=0. All payload outputs are 0, and out_opcode=OPC_NOOP.
//  Latency: one cycle. A payload accepted at edge N is driven from edge N onward.
//  accept = in_valid & in_ready. Definition: in_ready = (~out_valid | out_ready) & ~hazard.
//  Registered payload holds stable while out_valid & ~out_ready.
//  Edge update, in priority order:
//    1. flush: out_valid<=0, and the incoming instruction is dropped.
//    2. accept: load the payload, out_valid<=1.
//    3. out_ready: out_valid<=0.
//  Forwarding (applied to rs1 and rs2 independently, at capture):
//    - An index of 0 always yields 0.
//    - Otherwise, the EX/MEM match (ex_fwd_valid & rd==rs & ~ex_fwd_is_load) wins.
//    - Otherwise, the MEM/WB match wins.
//    - Otherwise, the register-file data is used.
//  Usage rules:
//    - use_rs1 is true for all opcodes except LUI, AUIPC, JAL, NOOP, and CSR when funct[2]=1.
//    - use_rs2 is true for RTYPE, BRANCH and STORE only.
//  hazard = in_valid & ex_fwd_valid & ex_fwd_is_load & ex_fwd_rd!=0 & ((use_rs1 & rs1 match) | (use_rs2 & rs2 match)).
//  While hazard is set, in_ready=0 and the upstream holds. Hazard does not bubble-fill the held payload.
//  Operand select:
//    - A = pc for AUIPC, JAL and BRANCH; A = fwd_rs1 otherwise; LUI sets A=0.
//    - B = fwd_rs2 for RTYPE.
//    - CSR: B = fwd_rs1 when funct[2]=0, else imm.
//    - All other opcodes: B = imm.
//  out_store_data = fwd_rs2 for every opcode.
//  Unknown opcode: captured as-is, with A = fwd_rs1 and B = imm.
//  Reset asserted mid-stall or mid-hold: everything clears immediately. in_ready is 1 after release.
//  Flush and hazard in the same cycle: flush wins, and in_ready stays at the hazard value.
// STRUCTURE
//  Shared include Pipeline.vh holds the operand-select encodings (ASEL_RS1/PC/ZERO,
//  BSEL_RS2/IMM/RS1) and the use_rs1/use_rs2 opcode table. Opcode values come from Opcode.vh.
//  One sub-module, fwd_mux: (rs, rf_data, ex/wb forward fields) -> forwarded value. It is
//  instantiated twice.
// TESTING
//  1. RTYPE ADD, rs1=5, rs2=6, no forwarding, rf=0x10 and 0x20 -> next cycle: out_A=0x10, out_B=0x20, out_valid=1.
//  2. ex_fwd rd=5 with 0xAA and wb_fwd rd=5 with 0xBB -> out_A=0xAA. With rs1=0 -> out_A=0.
//  3. ex_fwd_is_load=1, rd=6, STORE using rs2=6 -> in_ready=0. Drop is_load -> accepted with rf data.
//  4. out_ready=0 held 3 cycles while new inputs toggle -> outputs unchanged, in_ready=0.
//  5. flush with in_valid=1 -> out_valid=0 next cycle. AUIPC pc=0x100, imm=0x2000 -> A=0x100, B=0x2000.
//  6. Reset_n low mid-hold -> out_valid=0 and out_opcode=OPC_NOOP asynchronously.

Source files
------------

// File: rtl/id_ex_stage_pkg.sv
// id_ex_stage_pkg: shared definitions for the ID/EX pipeline register.
//   - Datapath widths.
//   - Opcode encodings. Plain constants rather than an enum, so unknown opcodes pass through.
//   - Operand-select encodings.
//   - Per-opcode register-usage and operand-select tables.
package id_ex_stage_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned REG_ADDR_W = 5;

  localparam logic [6:0] OPC_NOOP   = 7'b0000000;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_ITYPE  = 7'b0010011;
  localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
  localparam logic [6:0] OPC_CSR    = 7'b1110011;

  typedef enum logic [1:0] {ASEL_RS1, ASEL_PC, ASEL_ZERO} asel_e;
  typedef enum logic [1:0] {BSEL_RS2, BSEL_IMM, BSEL_RS1} bsel_e;

  // funct3[2] marks the CSR-immediate forms, which read zimm instead of rs1.
  function automatic logic use_rs1(input logic [6:0] opc, input logic [2:0] funct);
    case (opc)
      OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_NOOP: use_rs1 = 1'b0;
      OPC_CSR:                               use_rs1 = ~funct[2];
      default:                               use_rs1 = 1'b1;
    endcase
  endfunction

  function automatic logic use_rs2(input logic [6:0] opc);
    use_rs2 = (opc == OPC_RTYPE) || (opc == OPC_BRANCH) || (opc == OPC_STORE);
  endfunction

  function automatic asel_e a_sel(input logic [6:0] opc);
    case (opc)
      OPC_AUIPC, OPC_JAL, OPC_BRANCH: a_sel = ASEL_PC;
      OPC_LUI:                        a_sel = ASEL_ZERO;
      default:                        a_sel = ASEL_RS1;
    endcase
  endfunction

  function automatic bsel_e b_sel(input logic [6:0] opc, input logic [2:0] funct);
    case (opc)
      OPC_RTYPE: b_sel = BSEL_RS2;
      OPC_CSR:   b_sel = funct[2] ? BSEL_IMM : BSEL_RS1;
      default:   b_sel = BSEL_IMM;
    endcase
  endfunction

endpackage

// File: rtl/id_ex_stage_if.sv
// id_ex_stage_if: bundles the ID/EX stage traffic.
//   - Upstream decoded instruction with its valid/ready handshake, and flush.
//   - EX/MEM and MEM/WB forwarding fields.
//   - Execute-stage payload with its valid/ready handshake.
// Modports:
//   - slave: the stage's own view.
//   - master: the surrounding pipeline or a testbench.
interface id_ex_stage_if #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned REG_ADDR_W = 5
);
  logic                  flush;
  logic                  in_valid;
  logic                  in_ready;
  logic [6:0]            in_opcode;
  logic [2:0]            in_funct;
  logic                  in_add_rshift;
  logic [XLEN-1:0]       in_pc;
  logic [XLEN-1:0]       in_imm;
  logic [REG_ADDR_W-1:0] in_rs1;
  logic [REG_ADDR_W-1:0] in_rs2;
  logic [XLEN-1:0]       in_rs1_data;
  logic [XLEN-1:0]       in_rs2_data;
  logic [REG_ADDR_W-1:0] in_rd;
  logic                  ex_fwd_valid;
  logic                  ex_fwd_is_load;
  logic [REG_ADDR_W-1:0] ex_fwd_rd;
  logic [XLEN-1:0]       ex_fwd_data;
  logic                  wb_fwd_valid;
  logic [REG_ADDR_W-1:0] wb_fwd_rd;
  logic [XLEN-1:0]       wb_fwd_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [6:0]            out_opcode;
  logic [2:0]            out_funct;
  logic                  out_add_rshift;
  logic [XLEN-1:0]       out_A;
  logic [XLEN-1:0]       out_B;
  logic [XLEN-1:0]       out_store_data;
  logic [REG_ADDR_W-1:0] out_rd;
  logic [XLEN-1:0]       out_pc;

  modport slave (
    input  flush, in_valid, in_opcode, in_funct, in_add_rshift, in_pc, in_imm,
           in_rs1, in_rs2, in_rs1_data, in_rs2_data, in_rd,
           ex_fwd_valid, ex_fwd_is_load, ex_fwd_rd, ex_fwd_data,
           wb_fwd_valid, wb_fwd_rd, wb_fwd_data, out_ready,
    output in_ready, out_valid, out_opcode, out_funct, out_add_rshift,
           out_A, out_B, out_store_data, out_rd, out_pc
  );

  modport master (
    output flush, in_valid, in_opcode, in_funct, in_add_rshift, in_pc, in_imm,
           in_rs1, in_rs2, in_rs1_data, in_rs2_data, in_rd,
           ex_fwd_valid, ex_fwd_is_load, ex_fwd_rd, ex_fwd_data,
           wb_fwd_valid, wb_fwd_rd, wb_fwd_data, out_ready,
    input  in_ready, out_valid, out_opcode, out_funct, out_add_rshift,
           out_A, out_B, out_store_data, out_rd, out_pc
  );
endinterface

// File: rtl/id_ex_stage_fwd_mux.sv
// id_ex_stage_fwd_mux: resolves one source operand against the bypass network.
// Ports:
//   - i_rs, i_rf_data: register index and register-file read data.
//   - i_ex_*: EX/MEM bypass fields.
//   - i_wb_*: MEM/WB bypass fields.
//   - o_data: forwarded operand value.
// Precedence, highest first:
//   1. x0 reads as zero.
//   2. Non-load EX/MEM result.
//   3. MEM/WB result.
//   4. Register file.
module id_ex_stage_fwd_mux #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned REG_ADDR_W = 5
) (
  input  logic [REG_ADDR_W-1:0] i_rs,
  input  logic [XLEN-1:0]       i_rf_data,
  input  logic                  i_ex_valid,
  input  logic                  i_ex_is_load,
  input  logic [REG_ADDR_W-1:0] i_ex_rd,
  input  logic [XLEN-1:0]       i_ex_data,
  input  logic                  i_wb_valid,
  input  logic [REG_ADDR_W-1:0] i_wb_rd,
  input  logic [XLEN-1:0]       i_wb_data,
  output logic [XLEN-1:0]       o_data
);

  always_comb begin
    o_data = i_rf_data;
    if (i_rs == '0) begin
      o_data = '0;
    end else if (i_ex_valid && !i_ex_is_load && (i_ex_rd == i_rs)) begin
      o_data = i_ex_data;
    end else if (i_wb_valid && (i_wb_rd == i_rs)) begin
      o_data = i_wb_data;
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register feeding ALUdec/ALU.
// Ports:
//   - Clock: rising-edge clock.
//   - Reset_n: asynchronous, active-low reset.
//   - bus: id_ex_stage_if slave view.
// Behaviour:
//   - Captures one decoded instruction per accept.
//   - Operands are bypassed at capture time, then A/B are selected.
//   - Stalls upstream on a load-use hazard.
//   - Flush drops both the held and the incoming instruction.
module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned REG_ADDR_W = 5
) (
  input logic           Clock,
  input logic           Reset_n,
  id_ex_stage_if.slave  bus
);

  logic [XLEN-1:0] w_fwd_rs1;
  logic [XLEN-1:0] w_fwd_rs2;
  logic [XLEN-1:0] w_a;
  logic [XLEN-1:0] w_b;
  logic            w_hazard;
  logic            w_in_ready;
  logic            w_accept;
  asel_e           w_asel;
  bsel_e           w_bsel;

  logic                  r_valid;
  logic [6:0]            r_opcode;
  logic [2:0]            r_funct;
  logic                  r_add_rshift;
  logic [XLEN-1:0]       r_a;
  logic [XLEN-1:0]       r_b;
  logic [XLEN-1:0]       r_store_data;
  logic [REG_ADDR_W-1:0] r_rd;
  logic [XLEN-1:0]       r_pc;

  id_ex_stage_fwd_mux #(.XLEN(XLEN), .REG_ADDR_W(REG_ADDR_W)) u_fwd_rs1 (
    .i_rs         (bus.in_rs1),
    .i_rf_data    (bus.in_rs1_data),
    .i_ex_valid   (bus.ex_fwd_valid),
    .i_ex_is_load (bus.ex_fwd_is_load),
    .i_ex_rd      (bus.ex_fwd_rd),
    .i_ex_data    (bus.ex_fwd_data),
    .i_wb_valid   (bus.wb_fwd_valid),
    .i_wb_rd      (bus.wb_fwd_rd),
    .i_wb_data    (bus.wb_fwd_data),
    .o_data       (w_fwd_rs1)
  );

  id_ex_stage_fwd_mux #(.XLEN(XLEN), .REG_ADDR_W(REG_ADDR_W)) u_fwd_rs2 (
    .i_rs         (bus.in_rs2),
    .i_rf_data    (bus.in_rs2_data),
    .i_ex_valid   (bus.ex_fwd_valid),
    .i_ex_is_load (bus.ex_fwd_is_load),
    .i_ex_rd      (bus.ex_fwd_rd),
    .i_ex_data    (bus.ex_fwd_data),
    .i_wb_valid   (bus.wb_fwd_valid),
    .i_wb_rd      (bus.wb_fwd_rd),
    .i_wb_data    (bus.wb_fwd_data),
    .o_data       (w_fwd_rs2)
  );

  // A pending load cannot be bypassed, so hold upstream until its data reaches MEM/WB.
  always_comb begin
    w_hazard = bus.in_valid && bus.ex_fwd_valid && bus.ex_fwd_is_load &&
               (bus.ex_fwd_rd != '0) &&
               ((use_rs1(bus.in_opcode, bus.in_funct) && (bus.in_rs1 == bus.ex_fwd_rd)) ||
                (use_rs2(bus.in_opcode) && (bus.in_rs2 == bus.ex_fwd_rd)));
    w_in_ready = (!r_valid || bus.out_ready) && !w_hazard;
    w_accept   = bus.in_valid && w_in_ready;
  end

  always_comb begin
    w_asel = a_sel(bus.in_opcode);
    w_bsel = b_sel(bus.in_opcode, bus.in_funct);
    w_a    = w_fwd_rs1;
    w_b    = bus.in_imm;
    case (w_asel)
      ASEL_PC:   w_a = bus.in_pc;
      ASEL_ZERO: w_a = '0;
      default:   w_a = w_fwd_rs1;
    endcase
    case (w_bsel)
      BSEL_RS2: w_b = w_fwd_rs2;
      BSEL_RS1: w_b = w_fwd_rs1;
      default:  w_b = bus.in_imm;
    endcase
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      r_valid      <= 1'b0;
      r_opcode     <= OPC_NOOP;
      r_funct      <= '0;
      r_add_rshift <= 1'b0;
      r_a          <= '0;
      r_b          <= '0;
      r_store_data <= '0;
      r_rd         <= '0;
      r_pc         <= '0;
    end else if (bus.flush) begin
      r_valid <= 1'b0;
    end else if (w_accept) begin
      r_valid      <= 1'b1;
      r_opcode     <= bus.in_opcode;
      r_funct      <= bus.in_funct;
      r_add_rshift <= bus.in_add_rshift;
      r_a          <= w_a;
      r_b          <= w_b;
      r_store_data <= w_fwd_rs2;
      r_rd         <= bus.in_rd;
      r_pc         <= bus.in_pc;
    end else if (bus.out_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign bus.in_ready       = w_in_ready;
  assign bus.out_valid      = r_valid;
  assign bus.out_opcode     = r_opcode;
  assign bus.out_funct      = r_funct;
  assign bus.out_add_rshift = r_add_rshift;
  assign bus.out_A          = r_a;
  assign bus.out_B          = r_b;
  assign bus.out_store_data = r_store_data;
  assign bus.out_rd         = r_rd;
  assign bus.out_pc         = r_pc;

endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed self-checking bench for id_ex_stage.
module tb_id_ex_stage;
  import id_ex_stage_pkg::*;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;

  id_ex_stage_if #(.XLEN(32), .REG_ADDR_W(5)) bus ();

  id_ex_stage #(.XLEN(32), .REG_ADDR_W(5)) dut (
    .Clock   (clk),
    .Reset_n (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [6:0]  opc;
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] b;
  } vec_t;

  vec_t tbl [8];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.flush          = 1'b0;
    bus.in_valid       = 1'b0;
    bus.in_opcode      = OPC_NOOP;
    bus.in_funct       = '0;
    bus.in_add_rshift  = 1'b0;
    bus.in_pc          = '0;
    bus.in_imm         = '0;
    bus.in_rs1         = '0;
    bus.in_rs2         = '0;
    bus.in_rs1_data    = '0;
    bus.in_rs2_data    = '0;
    bus.in_rd          = '0;
    bus.ex_fwd_valid   = 1'b0;
    bus.ex_fwd_is_load = 1'b0;
    bus.ex_fwd_rd      = '0;
    bus.ex_fwd_data    = '0;
    bus.wb_fwd_valid   = 1'b0;
    bus.wb_fwd_rd      = '0;
    bus.wb_fwd_data    = '0;
    bus.out_ready      = 1'b1;
  endtask

  task automatic set_instr(input logic [6:0] opc, input logic [2:0] f,
                           input logic [4:0] rs1, input logic [4:0] rs2,
                           input logic [31:0] d1, input logic [31:0] d2);
    bus.in_valid    = 1'b1;
    bus.in_opcode   = opc;
    bus.in_funct    = f;
    bus.in_rs1      = rs1;
    bus.in_rs2      = rs2;
    bus.in_rs1_data = d1;
    bus.in_rs2_data = d2;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    n_cmp = 0;
    n_err = 0;
    tbl[0] = '{OPC_AUIPC,  3'b000, 32'h100, 32'h2000};
    tbl[1] = '{OPC_LUI,    3'b000, 32'h0,   32'h2000};
    tbl[2] = '{OPC_JAL,    3'b000, 32'h100, 32'h2000};
    tbl[3] = '{OPC_BRANCH, 3'b000, 32'h100, 32'h2000};
    tbl[4] = '{OPC_CSR,    3'b001, 32'h33,  32'h33};
    tbl[5] = '{OPC_CSR,    3'b101, 32'h33,  32'h2000};
    tbl[6] = '{OPC_JALR,   3'b000, 32'h33,  32'h2000};
    tbl[7] = '{7'h7f,      3'b000, 32'h33,  32'h2000};

    // Reset state
    rst_n = 1'b0;
    idle_inputs();
    step();
    check("rst_valid", 32'(bus.out_valid), 32'd0);
    check("rst_opcode", 32'(bus.out_opcode), 32'(OPC_NOOP));
    check("rst_A", bus.out_A, 32'h0);
    check("rst_pc", bus.out_pc, 32'h0);
    check("rst_ready", 32'(bus.in_ready), 32'd1);
    rst_n = 1'b1;
    step();

    // 1: plain RTYPE, no bypass
    set_instr(OPC_RTYPE, 3'b000, 5'd5, 5'd6, 32'h10, 32'h20);
    bus.in_rd = 5'd7;
    #1;
    check("t1_ready", 32'(bus.in_ready), 32'd1);
    step();
    bus.in_valid = 1'b0;
    check("t1_valid", 32'(bus.out_valid), 32'd1);
    check("t1_A", bus.out_A, 32'h10);
    check("t1_B", bus.out_B, 32'h20);
    check("t1_rd", 32'(bus.out_rd), 32'd7);
    check("t1_sd", bus.out_store_data, 32'h20);
    step();
    check("t1_drain", 32'(bus.out_valid), 32'd0);

    // 2: bypass precedence
    bus.ex_fwd_valid = 1'b1; bus.ex_fwd_rd = 5'd5; bus.ex_fwd_data = 32'hAA;
    bus.wb_fwd_valid = 1'b1; bus.wb_fwd_rd = 5'd5; bus.wb_fwd_data = 32'hBB;
    set_instr(OPC_RTYPE, 3'b000, 5'd5, 5'd6, 32'h10, 32'h20);
    step();
    check("t2_ex_wins", bus.out_A, 32'hAA);
    set_instr(OPC_RTYPE, 3'b000, 5'd0, 5'd5, 32'h10, 32'h20);
    step();
    check("t2_x0", bus.out_A, 32'h0);
    check("t2_rs2_ex", bus.out_B, 32'hAA);
    bus.ex_fwd_valid = 1'b0;
    step();
    check("t2_rs2_wb", bus.out_B, 32'hBB);
    bus.ex_fwd_valid = 1'b1; bus.ex_fwd_is_load = 1'b1; bus.wb_fwd_valid = 1'b0;
    set_instr(OPC_RTYPE, 3'b000, 5'd0, 5'd0, 32'h10, 32'h20);
    bus.ex_fwd_rd = 5'd0;
    #1;
    check("t2_rd0_nohaz", 32'(bus.in_ready), 32'd1);
    idle_inputs();
    step();

    // 3: load-use stall on rs2 of a STORE
    bus.ex_fwd_valid = 1'b1; bus.ex_fwd_is_load = 1'b1; bus.ex_fwd_rd = 5'd6;
    bus.ex_fwd_data = 32'hDEAD;
    set_instr(OPC_STORE, 3'b010, 5'd1, 5'd6, 32'h11, 32'h66);
    bus.in_imm = 32'h8;
    #1;
    check("t3_stall", 32'(bus.in_ready), 32'd0);
    bus.in_opcode = OPC_ITYPE;
    #1;
    check("t3_itype_no_rs2", 32'(bus.in_ready), 32'd1);
    bus.in_opcode = OPC_STORE;
    step();
    check("t3_no_bubble_fill", 32'(bus.out_valid), 32'd0);
    bus.ex_fwd_is_load = 1'b0; bus.ex_fwd_valid = 1'b0;
    #1;
    check("t3_release", 32'(bus.in_ready), 32'd1);
    step();
    check("t3_A", bus.out_A, 32'h11);
    check("t3_B", bus.out_B, 32'h8);
    check("t3_sd", bus.out_store_data, 32'h66);

    // 4: backpressure hold
    bus.out_ready = 1'b0;
    set_instr(OPC_RTYPE, 3'b000, 5'd1, 5'd2, 32'h99, 32'h98);
    #1;
    check("t4_ready_low", 32'(bus.in_ready), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      bus.in_rs1_data = 32'h100 + 32'(i);
      bus.in_funct    = 3'(i + 1);
      #1;
      check("t4_hold_valid", 32'(bus.out_valid), 32'd1);
      check("t4_hold_opc", 32'(bus.out_opcode), 32'(OPC_STORE));
      check("t4_hold_A", bus.out_A, 32'h11);
      check("t4_hold_ready", 32'(bus.in_ready), 32'd0);
    end
    bus.out_ready = 1'b1;
    bus.in_rs1_data = 32'h77;
    bus.in_funct = 3'b000;
    step();
    check("t4_new_A", bus.out_A, 32'h77);
    check("t4_new_opc", 32'(bus.out_opcode), 32'(OPC_RTYPE));

    // 5: flush kills held and incoming
    bus.out_ready = 1'b0;
    bus.flush = 1'b1;
    set_instr(OPC_RTYPE, 3'b000, 5'd1, 5'd2, 32'h55, 32'h56);
    step();
    bus.flush = 1'b0;
    bus.in_valid = 1'b0;
    check("t5_flushed", 32'(bus.out_valid), 32'd0);
    check("t5_payload_kept", bus.out_A, 32'h77);
    bus.flush = 1'b1;
    bus.ex_fwd_valid = 1'b1; bus.ex_fwd_is_load = 1'b1; bus.ex_fwd_rd = 5'd6;
    set_instr(OPC_STORE, 3'b010, 5'd1, 5'd6, 32'h11, 32'h66);
    #1;
    check("t5_flush_haz_ready", 32'(bus.in_ready), 32'd0);
    step();
    idle_inputs();

    // Operand-select table, rs1=3/rs2=4 without bypass
    bus.in_pc = 32'h100;
    bus.in_imm = 32'h2000;
    for (int i = 0; i < 8; i++) begin
      set_instr(tbl[i].opc, tbl[i].f, 5'd3, 5'd4, 32'h33, 32'h44);
      step();
      check("sel_A", bus.out_A, tbl[i].a);
      check("sel_B", bus.out_B, tbl[i].b);
      check("sel_sd", bus.out_store_data, 32'h44);
      check("sel_opc", 32'(bus.out_opcode), 32'(tbl[i].opc));
    end
    check("sel_pc", bus.out_pc, 32'h100);

    // 6: asynchronous reset while holding
    bus.out_ready = 1'b0;
    set_instr(OPC_RTYPE, 3'b000, 5'd1, 5'd2, 32'h12, 32'h34);
    step();
    check("t6_hold_valid", 32'(bus.out_valid), 32'd1);
    #3;
    rst_n = 1'b0;
    #1;
    check("t6_async_valid", 32'(bus.out_valid), 32'd0);
    check("t6_async_opc", 32'(bus.out_opcode), 32'(OPC_NOOP));
    check("t6_async_A", bus.out_A, 32'h0);
    step();
    rst_n = 1'b1;
    bus.in_valid = 1'b0;
    step();
    check("t6_ready_after", 32'(bus.in_ready), 32'd1);
    check("t6_valid_after", 32'(bus.out_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
